// File: rtl/beta_mem_pkg.sv
// Shared types and constants for the beta memory responder: the FSM state
// encoding, the fault classification codes and the request classifier.
package beta_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2,
        RECOVER = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE  = 2'd0,
        FAULT_RANGE = 2'd1,
        FAULT_BOTH  = 2'd2
    } fault_e;

    // Wide enough to hold LATENCY-1 for the largest legal LATENCY (15).
    localparam int CNT_W = 4;

    // Decide at acceptance whether a request will complete as a fault.
    // Asking for read and write at once takes precedence over the range check.
    function automatic fault_e classify(input logic        re,
                                        input logic        we,
                                        input logic [29:0] word,
                                        input int unsigned depth);
        if (re && we) begin
            return FAULT_BOTH;
        end
        if ({2'b00, word} >= depth) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/beta_mem_array.sv
// Single-port 32-bit synchronous RAM. Read-first: the registered read data
// always reflects the word at i_addr as it was before this edge's write.
// Contents are never reset.
module beta_mem_array #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Write on request and register the addressed word every cycle.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/beta_mem_responder.sv
// Memory responder for the MMU. A request is accepted in IDLE, waits in BUSY
// so that the RESPOND cycle is the LATENCY-th cycle after the accepting edge,
// pulses MemDataReady for that one cycle, then spends one RECOVER cycle with
// the enables ignored. The request type, address, data and fault class are
// all frozen at acceptance, so later changes on the inputs have no effect.
//
// Handshake: MemReadEnable/MemWriteEnable act as a valid that the MMU holds
// until it sees MemDataReady; MemDataReady is the one-cycle completion strobe
// and AccessFault only has meaning while MemDataReady is high.
module beta_mem_responder
    import beta_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MemAddress,
    input  logic [31:0] MemDataOut,
    output logic [31:0] MemDataIn,
    input  logic        MemReadEnable,
    input  logic        MemWriteEnable,
    output logic        MemDataReady,
    output logic        AccessFault,
    output state_e      o_dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e              r_state;
    state_e              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_enter_respond;

    logic [AW-1:0]       r_word;
    logic [31:0]         r_wdata;
    logic                r_is_read;
    logic                r_is_write;
    fault_e              r_fault;
    logic [31:0]         r_data_in;

    logic                w_req;
    fault_e              w_fault_in;
    fault_e              w_resp_fault;
    logic                w_resp_read;
    logic                w_resp_write;
    logic                w_ram_we;
    logic [AW-1:0]       w_ram_addr;
    logic [31:0]         w_ram_wdata;
    logic [31:0]         w_ram_rdata;
    logic                w_show_ram;
    logic                w_unused_addr_lsb;

    assign w_req             = MemReadEnable | MemWriteEnable;
    assign w_fault_in        = classify(MemReadEnable, MemWriteEnable, MemAddress[31:2], DEPTH_WORDS);
    assign w_unused_addr_lsb = ^MemAddress[1:0];

    // With LATENCY=1 the accepting edge is also the edge entering RESPOND,
    // so the response attributes come straight from the inputs in IDLE.
    assign w_resp_fault = (r_state == IDLE) ? w_fault_in     : r_fault;
    assign w_resp_read  = (r_state == IDLE) ? MemReadEnable  : r_is_read;
    assign w_resp_write = (r_state == IDLE) ? MemWriteEnable : r_is_write;

    assign w_ram_addr  = (r_state == IDLE) ? MemAddress[AW+1:2] : r_word;
    assign w_ram_wdata = (r_state == IDLE) ? MemDataOut         : r_wdata;
    // Reset on the would-be commit edge aborts the write.
    assign w_ram_we    = w_enter_respond && w_resp_write && (w_resp_fault == FAULT_NONE) && !rst;

    // The RAM reads on the edge entering RESPOND; its output is shown
    // directly during RESPOND and latched into r_data_in as RESPOND ends.
    assign w_show_ram = (r_state == RESPOND) && r_is_read && (r_fault == FAULT_NONE);

    assign MemDataIn    = w_show_ram ? w_ram_rdata : r_data_in;
    assign MemDataReady = (r_state == RESPOND);
    assign AccessFault  = (r_state == RESPOND) && (r_fault != FAULT_NONE);
    assign o_dbg_state  = r_state;

    beta_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: the counter is loaded with LATENCY-1 and RESPOND is
    // entered on the edge where it counts down to zero.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_enter_respond = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (LATENCY == 1) begin
                        w_state_next    = RESPOND;
                        w_enter_respond = 1'b1;
                        w_cnt_next      = '0;
                    end else begin
                        w_state_next = BUSY;
                        w_cnt_next   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_next      = '0;
                    w_state_next    = RESPOND;
                    w_enter_respond = 1'b1;
                end
            end
            RESPOND: begin
                w_state_next = RECOVER;
            end
            RECOVER: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Freeze the request when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word     <= '0;
            r_wdata    <= '0;
            r_is_read  <= 1'b0;
            r_is_write <= 1'b0;
            r_fault    <= FAULT_NONE;
        end else if ((r_state == IDLE) && w_req) begin
            r_word     <= MemAddress[AW+1:2];
            r_wdata    <= MemDataOut;
            r_is_read  <= MemReadEnable;
            r_is_write <= MemWriteEnable;
            r_fault    <= w_fault_in;
        end
    end

    // Held read data: zeroed by an out-of-range read, updated by a good read,
    // untouched by writes and by the both-enables fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_in <= '0;
        end else if (w_enter_respond && w_resp_read && (w_resp_fault == FAULT_RANGE)) begin
            r_data_in <= '0;
        end else if (w_show_ram) begin
            r_data_in <= w_ram_rdata;
        end
    end

endmodule

// File: tb/tb_beta_mem_responder.sv
// Bench for beta_mem_responder: one instance at LATENCY=4/DEPTH=4096 and one
// at LATENCY=1/DEPTH=64, driven through a shared access task and checked
// against a word-array model of the memory and the held read data.
module tb_beta_mem_responder;
    import beta_mem_pkg::*;

    localparam int LAT0   = 4;
    localparam int DEPTH0 = 4096;
    localparam int LAT1   = 1;
    localparam int DEPTH1 = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] addr0, wdata0, rdata0;
    logic        re0, we0, rdy0, flt0;
    state_e      dbg0;
    logic [31:0] addr1, wdata1, rdata1;
    logic        re1, we1, rdy1, flt1;
    state_e      dbg1;

    beta_mem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(LAT0)) dut (
        .clk            (clk),
        .rst            (rst),
        .MemAddress     (addr0),
        .MemDataOut     (wdata0),
        .MemDataIn      (rdata0),
        .MemReadEnable  (re0),
        .MemWriteEnable (we0),
        .MemDataReady   (rdy0),
        .AccessFault    (flt0),
        .o_dbg_state    (dbg0)
    );

    beta_mem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(LAT1)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .MemAddress     (addr1),
        .MemDataOut     (wdata1),
        .MemDataIn      (rdata1),
        .MemReadEnable  (re1),
        .MemWriteEnable (we1),
        .MemDataReady   (rdy1),
        .AccessFault    (flt1),
        .o_dbg_state    (dbg1)
    );

    // ---------------- scoreboard / model ----------------
    int          n_cmp;
    int          n_err;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [2][4096];
    logic [31:0] model_data_in [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic re, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            re0 = re; we0 = we; addr0 = addr; wdata0 = data;
        end else begin
            re1 = re; we1 = we; addr1 = addr; wdata1 = data;
        end
    endtask

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic get_flt(input int sel);
        return (sel == 0) ? flt0 : flt1;
    endfunction

    function automatic logic [31:0] get_data(input int sel);
        return (sel == 0) ? rdata0 : rdata1;
    endfunction

    // Call at #1 after an edge with the target DUT idle. Raises the request,
    // scrambles address/data after acceptance, waits for the strobe and checks
    // it lands on cycle LATENCY after the accepting edge. Returns with the
    // DUT idle again and enables low.
    task automatic do_access(input int sel, input logic re, input logic we,
                             input logic [31:0] addr, input logic [31:0] data,
                             input string tag);
        int          depth;
        int          lat;
        int          n;
        logic [29:0] word;
        logic        exp_fault;
        logic [31:0] exp_data;
        depth = (sel == 0) ? DEPTH0 : DEPTH1;
        lat   = (sel == 0) ? LAT0 : LAT1;
        word  = addr[31:2];
        if (re && we) begin
            exp_fault = 1'b1;
            exp_data  = model_data_in[sel];
        end else if (word >= 30'(depth)) begin
            exp_fault = 1'b1;
            exp_data  = re ? 32'h0 : model_data_in[sel];
        end else begin
            exp_fault = 1'b0;
            if (re) begin
                exp_data = model_mem[sel][word];
            end else begin
                model_mem[sel][word] = data;
                exp_data = model_data_in[sel];
            end
        end
        model_data_in[sel] = exp_data;
        exp_q.push_back(exp_data);

        drive(sel, re, we, addr, data);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!get_rdy(sel)) begin
                check({tag, "_flt_qual"}, 32'(get_flt(sel)), 32'h0);
                drive(sel, re, we, $urandom, $urandom);
            end
        end while (!get_rdy(sel) && n < 40);
        check({tag, "_ready"}, 32'(get_rdy(sel)), 32'h1);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_fault"}, 32'(get_flt(sel)), 32'(exp_fault));
        check({tag, "_data"}, get_data(sel), exp_q.pop_front());
        drive(sel, 1'b0, 1'b0, $urandom, $urandom);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, 32'(get_rdy(sel)), 32'h0);
        check({tag, "_data_hold"}, get_data(sel), model_data_in[sel]);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          pulses;
        logic [5:0]  pat;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        model_data_in[0] = 32'h0;
        model_data_in[1] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy0), 32'h0);
        check("rst_fault", 32'(flt0), 32'h0);
        check("rst_data", rdata0, 32'h0);
        check("rst_state", 32'(dbg0), 32'(IDLE));
        check("rst_data1", rdata1, 32'h0);

        // Released together with the first request: acceptance on the very
        // next edge is what the latency check inside do_access confirms.
        rst = 1'b0;
        for (int w = 0; w < 32; w++) begin
            do_access(0, 1'b0, 1'b1, 32'(w) << 2, $urandom, "prefill0");
            do_access(1, 1'b0, 1'b1, 32'(w) << 2, $urandom, "prefill1");
        end

        // Basic write then read.
        do_access(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, "w100");
        do_access(0, 1'b1, 1'b0, 32'h100, 32'h0, "r100");
        check("r100_direct", rdata0, 32'hDEADBEEF);

        // Low address bits ignored.
        do_access(0, 1'b0, 1'b1, 32'h203, 32'h12345678, "w203");
        do_access(0, 1'b1, 1'b0, 32'h200, 32'h0, "r200");
        check("r200_direct", rdata0, 32'h12345678);

        // Out of range read and write; word 0 must survive the write.
        do_access(0, 1'b1, 1'b0, 32'h4000, 32'h0, "r_oor");
        check("r_oor_zero", rdata0, 32'h0);
        do_access(0, 1'b0, 1'b1, 32'h4000, 32'h55AA55AA, "w_oor");
        do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, "r0_after_oor");

        // Both enables at once.
        do_access(0, 1'b1, 1'b1, 32'h10, 32'hAAAA5555, "both");
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, "r10_after_both");

        // Reset while the write to 0x40 sits in BUSY.
        drive(0, 1'b0, 1'b1, 32'h40, 32'h1);
        @(posedge clk); #1;
        check("abort_busy", 32'(dbg0), 32'(BUSY));
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_data_in[0] = 32'h0;
        model_data_in[1] = 32'h0;
        check("abort_state", 32'(dbg0), 32'(IDLE));
        check("abort_data", rdata0, 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rdy0) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'h0);
        do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, "r40_after_abort");

        // LATENCY=1 with the read enable held for six cycles.
        do_access(1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, "l1_w8");
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat = {pat[4:0], rdy1};
            if (rdy1) begin
                check("l1_hold_data", rdata1, 32'hCAFEF00D);
                check("l1_hold_fault", 32'(flt1), 32'h0);
            end else begin
                check("l1_hold_flt_qual", 32'(flt1), 32'h0);
            end
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        model_data_in[1] = 32'hCAFEF00D;
        check("l1_hold_pattern", 32'(pat), 32'b100100);
        @(posedge clk); #1;

        // Randomized mix on both instances.
        for (int i = 0; i < 48; i++) begin
            int          sel;
            int          r;
            int          depth;
            logic [29:0] word;
            logic [1:0]  lsb;
            logic        re;
            logic        we;
            sel   = (i % 3 == 2) ? 1 : 0;
            depth = (sel == 0) ? DEPTH0 : DEPTH1;
            r     = $urandom_range(0, 99);
            word  = 30'($urandom_range(0, 31));
            lsb   = 2'($urandom_range(0, 3));
            re    = 1'b1;
            we    = 1'b0;
            if (r < 50) begin
                re = 1'b1; we = 1'b0;
            end else if (r < 80) begin
                re = 1'b0; we = 1'b1;
            end else if (r < 92) begin
                word = 30'(depth + $urandom_range(0, 1000));
                re   = $urandom_range(0, 1) == 1;
                we   = !re;
            end else begin
                re = 1'b1; we = 1'b1;
            end
            do_access(sel, re, we, {word, lsb}, $urandom, sel == 0 ? "rand0" : "rand1");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
